// File: rtl/uart_rx_fifo.sv
// Oversampling 8N1 UART receiver feeding a byte FIFO with a valid/ready output.
// Define UART_RX_PARITY_EN to receive 8E1 frames (even parity checked, bad bytes dropped).
module uart_rx_fifo #(
    parameter int CLK_HZ     = 100000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          I_clk,
    input  logic                          I_rst,
    input  logic                          I_uart_rx,
    output logic [7:0]                    O_data,
    output logic                          O_valid,
    input  logic                          I_ready,
    output logic [$clog2(FIFO_DEPTH):0]   O_count,
    output logic                          O_frame_err,
    output logic                          O_parity_err,
    output logic                          O_overrun
);

    localparam int DIV   = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SC_W  = $clog2(OVERSAMPLE);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int CW    = AW + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_RX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP,
        ST_BREAK
    } state_t;

    state_t             state, state_nxt;
    logic               rx_p0, rx_p1, rxs;
    logic [DIV_W-1:0]   div_cnt;
    logic [SC_W-1:0]    scnt;
    logic [2:0]         bit_cnt;
    logic [7:0]         shreg;
    logic               tick, sample;
    logic               push_req, frame_set;
    logic               par_bad;
`ifdef UART_RX_PARITY_EN
    logic               par_set;
`endif

    logic [7:0]         mem [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [CW-1:0]      count;
    logic               full, pop, do_push, drop;

    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

    // Input synchronizer: idles at the line's mark level
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            rx_p0 <= 1'b1;
            rx_p1 <= 1'b1;
        end else begin
            rx_p0 <= I_uart_rx;
            rx_p1 <= rx_p0;
        end
    end
    assign rxs = rx_p1;

    // Tick and sample counters are held at zero in IDLE so each frame is timed from its start edge
    always_ff @(posedge I_clk) begin
        if (I_rst || state == ST_IDLE) begin
            div_cnt <= '0;
            scnt    <= '0;
        end else begin
            if (div_cnt == DIV_W'(DIV - 1))
                div_cnt <= '0;
            else
                div_cnt <= div_cnt + 1'b1;
            if (tick) begin
                if (scnt == SC_W'(OVERSAMPLE - 1))
                    scnt <= '0;
                else
                    scnt <= scnt + 1'b1;
            end
        end
    end

    assign tick   = (state != ST_IDLE) && (div_cnt == DIV_W'(DIV - 1));
    assign sample = tick && (scnt == SC_W'(OVERSAMPLE / 2 - 1));

    always_ff @(posedge I_clk) begin
        if (I_rst || state == ST_IDLE)
            bit_cnt <= 3'd0;
        else if (state == ST_DATA && sample)
            bit_cnt <= bit_cnt + 3'd1;
    end

    always_ff @(posedge I_clk) begin
        if (state == ST_DATA && sample)
            shreg <= {rxs, shreg[7:1]};
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge I_clk) begin
        if (I_rst || state == ST_IDLE)
            par_bad <= 1'b0;
        else if (par_set)
            par_bad <= 1'b1;
    end
`else
    assign par_bad = 1'b0;
`endif

    always_ff @(posedge I_clk) begin
        if (I_rst)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        push_req  = 1'b0;
        frame_set = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_set   = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (!rxs)
                    state_nxt = ST_START;
            end
            ST_START: begin
                if (sample)
                    state_nxt = rxs ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (sample && bit_cnt == 3'd7)
`ifdef UART_RX_PARITY_EN
                    state_nxt = ST_PARITY;
`else
                    state_nxt = ST_STOP;
`endif
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (sample) begin
                    par_set   = (rxs != even_parity(shreg));
                    state_nxt = ST_STOP;
                end
            end
`endif
            // Leaving at stop-bit mid leaves half a bit to catch the next start edge
            ST_STOP: begin
                if (sample) begin
                    if (rxs) begin
                        push_req  = !par_bad;
                        state_nxt = ST_IDLE;
                    end else begin
                        frame_set = 1'b1;
                        state_nxt = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                if (rxs)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // A full FIFO still accepts a byte when the head is popped in the same cycle
    assign full    = (count == CW'(FIFO_DEPTH));
    assign pop     = O_valid && I_ready;
    assign do_push = push_req && (!full || pop);
    assign drop    = push_req && full && !pop;

    always_ff @(posedge I_clk) begin
        if (do_push)
            mem[wr_ptr] <= shreg;
    end

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign O_valid = (count != '0);
    assign O_data  = O_valid ? mem[rd_ptr] : 8'h00;
    assign O_count = count;

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            O_frame_err <= 1'b0;
            O_overrun   <= 1'b0;
        end else begin
            O_frame_err <= frame_set;
            O_overrun   <= drop;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge I_clk) begin
        if (I_rst)
            O_parity_err <= 1'b0;
        else
            O_parity_err <= par_set;
    end
`else
    assign O_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo, run at a scaled line rate of 64 clocks per bit.
// Serial frames are driven on the line; pops and error pulses are tallied on the falling edge.
module tb_uart_rx_fifo;

    localparam int CLK_HZ_T = 1000000;
    localparam int BAUD_T   = 15000;
    localparam int OS_T     = 16;
    localparam int DEPTH_T  = 8;
    // 1e6 / (15000*16) = 4.17 -> 4 clocks per tick, 16 ticks per bit
    localparam int BIT      = 64;
`ifdef UART_RX_PARITY_EN
    localparam int LAT_NOM  = 10 * BIT + BIT / 2;
`else
    localparam int LAT_NOM  = 9 * BIT + BIT / 2;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_line;
    logic       ready;
    logic [7:0] data;
    logic       valid;
    logic [3:0] cnt;
    logic       ferr, perr, ovr;

    int checks = 0;
    int errors = 0;
    int frame_cnt = 0, par_cnt = 0, ovr_cnt = 0, valid_cycles = 0;
    int lat = 0;
    logic [7:0] popped [$];

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .CLK_HZ(CLK_HZ_T), .BAUD(BAUD_T), .OVERSAMPLE(OS_T), .FIFO_DEPTH(DEPTH_T)
    ) dut (
        .I_clk(clk), .I_rst(rst), .I_uart_rx(rx_line),
        .O_data(data), .O_valid(valid), .I_ready(ready), .O_count(cnt),
        .O_frame_err(ferr), .O_parity_err(perr), .O_overrun(ovr)
    );

    always @(negedge clk) begin
        if (ferr) frame_cnt++;
        if (perr) par_cnt++;
        if (ovr) ovr_cnt++;
        if (valid) valid_cycles++;
        if (valid && ready) popped.push_back(data);
    end

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
        rx_line = 1'b0;
        clks(BIT);
        for (int i = 0; i < 8; i++) begin
            rx_line = b[i];
            clks(BIT);
        end
`ifdef UART_RX_PARITY_EN
        rx_line = par;
        clks(BIT);
`endif
        rx_line = stop;
        clks(BIT);
        rx_line = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1; rx_line = 1'b1; ready = 1'b0;
        clks(5);
        rst = 1'b0;
        clks(2);
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", valid); end
        checks++; if (cnt !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", cnt); end
        checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data got %02h want 00", data); end
        checks++; if ({ferr, perr, ovr} !== 3'b000) begin errors++; $display("FAIL reset_errs got %03b want 000", {ferr, perr, ovr}); end
    endtask

    task automatic test_single;
        int p0, v0, f0, o0;
        ready = 1'b1;
        p0 = popped.size(); v0 = valid_cycles; f0 = frame_cnt; o0 = ovr_cnt;
        fork
            send_frame(8'h55, 1'b0, 1'b1);
            begin
                lat = 0;
                for (int i = 1; i <= 12 * BIT; i++) begin
                    @(posedge clk);
                    @(negedge clk);
                    if (valid) begin
                        lat = i;
                        break;
                    end
                end
            end
        join
        clks(BIT);
        checks++; if (lat < LAT_NOM || lat > LAT_NOM + 6) begin errors++; $display("FAIL single_latency got %0d want %0d..%0d", lat, LAT_NOM, LAT_NOM + 6); end
        checks++; if (popped.size() - p0 !== 1) begin errors++; $display("FAIL single_pops got %0d want 1", popped.size() - p0); end
        else begin
            checks++; if (popped[p0] !== 8'h55) begin errors++; $display("FAIL single_data got %02h want 55", popped[p0]); end
        end
        checks++; if (valid_cycles - v0 !== 1) begin errors++; $display("FAIL single_valid_cycles got %0d want 1", valid_cycles - v0); end
        checks++; if (cnt !== 4'd0) begin errors++; $display("FAIL single_count got %0d want 0", cnt); end
        checks++; if (frame_cnt - f0 + ovr_cnt - o0 !== 0) begin errors++; $display("FAIL single_err_pulses got %0d want 0", frame_cnt - f0 + ovr_cnt - o0); end
    endtask

    task automatic test_overrun;
        int p0, o0;
        logic [7:0] b;
        ready = 1'b0;
        o0 = ovr_cnt;
        for (int i = 1; i <= 8; i++) begin
            b = 8'(i);
            send_frame(b, ^b, 1'b1);
        end
        clks(BIT);
        checks++; if (cnt !== 4'd8) begin errors++; $display("FAIL ovr_count_full got %0d want 8", cnt); end
        checks++; if (ovr_cnt - o0 !== 0) begin errors++; $display("FAIL ovr_early got %0d want 0", ovr_cnt - o0); end
        checks++; if (valid !== 1'b1 || data !== 8'h01) begin errors++; $display("FAIL ovr_head got v%0b %02h want v1 01", valid, data); end
        send_frame(8'h09, 1'b0, 1'b1);
        clks(BIT);
        checks++; if (ovr_cnt - o0 !== 1) begin errors++; $display("FAIL ovr_pulse got %0d want 1", ovr_cnt - o0); end
        checks++; if (cnt !== 4'd8) begin errors++; $display("FAIL ovr_count_after got %0d want 8", cnt); end
        p0 = popped.size();
        ready = 1'b1;
        clks(20);
        ready = 1'b0;
        checks++; if (popped.size() - p0 !== 8) begin errors++; $display("FAIL ovr_drain_n got %0d want 8", popped.size() - p0); end
        else begin
            for (int i = 0; i < 8; i++) begin
                checks++; if (popped[p0 + i] !== 8'(i + 1)) begin errors++; $display("FAIL ovr_drain_%0d got %02h want %02h", i, popped[p0 + i], 8'(i + 1)); end
            end
        end
        checks++; if (cnt !== 4'd0) begin errors++; $display("FAIL ovr_drained_count got %0d want 0", cnt); end
    endtask

    task automatic test_glitch;
        int p0, f0;
        ready = 1'b1;
        p0 = popped.size(); f0 = frame_cnt;
        rx_line = 1'b0;
        clks(20);
        rx_line = 1'b1;
        clks(3 * BIT);
        checks++; if (popped.size() - p0 !== 0 || cnt !== 4'd0) begin errors++; $display("FAIL glitch_push got pops %0d count %0d want 0 0", popped.size() - p0, cnt); end
        checks++; if (frame_cnt - f0 !== 0) begin errors++; $display("FAIL glitch_err got %0d want 0", frame_cnt - f0); end
        send_frame(8'h5A, 1'b0, 1'b1);
        clks(BIT);
        checks++; if (popped.size() - p0 !== 1) begin errors++; $display("FAIL glitch_next_n got %0d want 1", popped.size() - p0); end
        else begin
            checks++; if (popped[p0] !== 8'h5A) begin errors++; $display("FAIL glitch_next_data got %02h want 5a", popped[p0]); end
        end
    endtask

    task automatic test_frame_err;
        int p0, f0, o0;
        ready = 1'b1;
        p0 = popped.size(); f0 = frame_cnt; o0 = ovr_cnt;
        send_frame(8'hA3, 1'b0, 1'b0);
        rx_line = 1'b0;
        clks(5 * BIT);
        rx_line = 1'b1;
        clks(2 * BIT);
        checks++; if (frame_cnt - f0 !== 1) begin errors++; $display("FAIL ferr_pulses got %0d want 1", frame_cnt - f0); end
        checks++; if (cnt !== 4'd0 || popped.size() - p0 !== 0) begin errors++; $display("FAIL ferr_push got count %0d pops %0d want 0 0", cnt, popped.size() - p0); end
        checks++; if (ovr_cnt - o0 !== 0) begin errors++; $display("FAIL ferr_overrun got %0d want 0", ovr_cnt - o0); end
        send_frame(8'h3C, 1'b0, 1'b1);
        clks(BIT);
        checks++; if (popped.size() - p0 !== 1) begin errors++; $display("FAIL ferr_next_n got %0d want 1", popped.size() - p0); end
        else begin
            checks++; if (popped[p0] !== 8'h3C) begin errors++; $display("FAIL ferr_next_data got %02h want 3c", popped[p0]); end
        end
        checks++; if (frame_cnt - f0 !== 1) begin errors++; $display("FAIL ferr_after_good got %0d want 1", frame_cnt - f0); end
    endtask

    task automatic test_full_pop;
        int p0, o0;
        logic [7:0] b;
        ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            b = 8'h10 + 8'(i);
            send_frame(b, ^b, 1'b1);
        end
        clks(BIT);
        checks++; if (cnt !== 4'd8) begin errors++; $display("FAIL fullpop_fill got %0d want 8", cnt); end
        p0 = popped.size(); o0 = ovr_cnt;
        fork
            send_frame(8'h18, 1'b0, 1'b1);
            begin
                repeat (lat - 1) @(posedge clk);
                #1 ready = 1'b1;
                @(posedge clk);
                #1 ready = 1'b0;
            end
        join
        clks(BIT);
        checks++; if (ovr_cnt - o0 !== 0) begin errors++; $display("FAIL fullpop_overrun got %0d want 0", ovr_cnt - o0); end
        checks++; if (cnt !== 4'd8) begin errors++; $display("FAIL fullpop_count got %0d want 8", cnt); end
        checks++; if (popped.size() - p0 !== 1) begin errors++; $display("FAIL fullpop_one_pop got %0d want 1", popped.size() - p0); end
        ready = 1'b1;
        clks(20);
        ready = 1'b0;
        checks++; if (popped.size() - p0 !== 9) begin errors++; $display("FAIL fullpop_drain_n got %0d want 9", popped.size() - p0); end
        else begin
            for (int i = 0; i < 9; i++) begin
                checks++; if (popped[p0 + i] !== 8'h10 + 8'(i)) begin errors++; $display("FAIL fullpop_order_%0d got %02h want %02h", i, popped[p0 + i], 8'h10 + 8'(i)); end
            end
        end
    endtask

    task automatic test_reset_midframe;
        int p0, f0;
        ready = 1'b1;
        p0 = popped.size(); f0 = frame_cnt;
        rx_line = 1'b0;
        clks(2 * BIT - 10);
        rst = 1'b1;
        rx_line = 1'b1;
        clks(3);
        rst = 1'b0;
        clks(12 * BIT);
        checks++; if (popped.size() - p0 !== 0 || cnt !== 4'd0) begin errors++; $display("FAIL midrst_push got pops %0d count %0d want 0 0", popped.size() - p0, cnt); end
        checks++; if (frame_cnt - f0 !== 0) begin errors++; $display("FAIL midrst_err got %0d want 0", frame_cnt - f0); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity;
        int p0, q0;
        ready = 1'b1;
        p0 = popped.size(); q0 = par_cnt;
        send_frame(8'h07, 1'b0, 1'b1);
        clks(BIT);
        checks++; if (par_cnt - q0 !== 1) begin errors++; $display("FAIL par_pulse got %0d want 1", par_cnt - q0); end
        checks++; if (popped.size() - p0 !== 0) begin errors++; $display("FAIL par_dropped got %0d want 0", popped.size() - p0); end
        send_frame(8'h07, 1'b1, 1'b1);
        clks(BIT);
        checks++; if (popped.size() - p0 !== 1) begin errors++; $display("FAIL par_good_n got %0d want 1", popped.size() - p0); end
        else begin
            checks++; if (popped[p0] !== 8'h07) begin errors++; $display("FAIL par_good_data got %02h want 07", popped[p0]); end
        end
        checks++; if (par_cnt - q0 !== 1) begin errors++; $display("FAIL par_good_err got %0d want 1", par_cnt - q0); end
    endtask
`endif

    initial begin
        test_reset;
        test_single;
        test_overrun;
        test_glitch;
        test_frame_err;
        test_full_pop;
        test_reset_midframe;
`ifdef UART_RX_PARITY_EN
        test_parity;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
